ram_io_responder: RTL and testbench
===================================

// Module: ram_io_responder
// PURPOSE
// - Bus-side responder for the CPU's 4-bit multiplexed bus, modelled on a 4002-class RAM/output chip.
// - Tracks the 8-phase instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3) from sync.
// - Latches SRC chip/register/character addresses and executes RAM I/O instructions (OPR=0xE).
// - Sits opposite the CPU datapath: it sinks data the CPU writes and sources data the CPU ALU reads.
// PARAMETERS
// - CHIP_ID  2'd0  chip number; compared against SRC data[3:2] at X2
// PORTS
// - clock    in   1  one bus phase per rising edge
// - reset_n  in   1  asynchronous, active-low reset
// - sync     in   1  high in X3; the next cycle is A1
// - cm_ram   in   1  CPU command line: X2 = SRC address, M2 = I/O instruction
// - data_in  in   4  bus value driven by the CPU
// - data_out out  4  bus value driven by this block; 0 when data_oe=0
// - data_oe  out  1  high only while this block drives the bus
// - port_out out  4  registered output port, loaded by WMP
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - phase=IDLE, sel=0, reg/char/opa=0, io_pend=0.
//   - All 4x16 main and 4x4 status nibbles = 0; port_out=0; data_oe=0; data_out=0.
// - Phase tracking:
//   - sync sampled high on any edge -> phase=A1 on the next edge, regardless of current phase.
//   - Otherwise phase advances A1..X3; X3 without sync -> IDLE.
//   - IDLE holds until sync. No execution happens in IDLE.
// - SRC:
//   - At X2 with cm_ram=1: sel = (data_in[3:2]==CHIP_ID); reg = data_in[1:0] (loaded only if selected); io_pend cleared.
//   - At the following X3, if sel: char = data_in.
//   - sel persists until the next SRC; a non-matching SRC clears it.
// - I/O decode:
//   - M1: opr_e = (data_in==4'hE).
//   - M2: if opr_e && cm_ram -> opa = data_in, io_pend=1.
//   - io_pend clears at X3.
// - Execute at X2 when io_pend && sel && !cm_ram:
//   - Writes (sample data_in at the X2 edge, storage updates that edge):
//     - 0 WRM: main[reg][char] = data_in
//     - 1 WMP: port_out = data_in
//     - 4-7 WR0-3: status[reg][opa[1:0]] = data_in
//   - Reads (combinational during X2: data_oe=1, data_out=value):
//     - 8 SBM / 9 RDM / B ADM: data_out = main[reg][char]
//     - C-F RD0-3: data_out = status[reg][opa[1:0]]
//   - 2 WRR, 3 WPM, A RDR: ignored; no drive, no write.
// - data_oe is never high outside X2, never high when sel=0, never high in the same phase as a write.
// - Contention: cm_ram=1 at X2 means SRC. Any pending I/O is cancelled for that cycle.
// - Widths: all indices are 2- or 4-bit and wrap naturally; there is no out-of-range case.
// - Reset mid-cycle: pending I/O is discarded; no write occurs; the block waits for sync.
// STRUCTURE
// - Shared header bus.vh (alongside datapath.vh):
//   - phase encodings PH_IDLE, PH_A1..PH_X3
//   - IO_WRM..IO_RD3 opcode constants
//   - OPR_IO = 4'hE
// - Sub-module bus_phase_counter: sync -> one-hot or encoded phase. The CPU-side sequencer reuses it.
// - Storage is a flop array with async clear; no SRAM macro.
// TESTING
// - Reset: pulse reset_n low mid-X1 -> data_oe=0, port_out=0, phase=IDLE immediately; all RAM reads then return 0.
// - CHIP_ID=1, SRC 4'b0110 / char 5, then WRM with 0xA; next cycle RDM -> data_out=0xA, data_oe=1 in X2 only.
// - SRC 4'b1010 (chip 2) then RDM -> data_oe=0 all cycle; WRM 0x3 -> main[2][5] unchanged.
// - WR2 with 0x7 then RD2 on same reg -> data_out=0x7; RD1 -> 0x0.
// - WMP with 0x9 -> port_out=0x9 after the X2 edge, held across later cycles; WRR/RDR -> no drive, no change.
// - Assert sync at M1 mid-cycle -> next phase A1; cm_ram at old M2 ignored, no I/O executed.
// - Reset during X1 with io_pend set -> no write at X2, data_oe stays 0.

Source files
------------

// File: rtl/ram_io_responder_pkg.sv
// Shared bus definitions for the 4-bit multiplexed CPU bus: phase encodings,
// RAM I/O opcodes (OPA field of OPR=0xE) and opcode class helpers.
package ram_io_responder_pkg;

  typedef enum logic [3:0] {
    PH_IDLE = 4'd0,
    PH_A1   = 4'd1,
    PH_A2   = 4'd2,
    PH_A3   = 4'd3,
    PH_M1   = 4'd4,
    PH_M2   = 4'd5,
    PH_X1   = 4'd6,
    PH_X2   = 4'd7,
    PH_X3   = 4'd8
  } phase_e;

  localparam logic [3:0] OPR_IO = 4'hE;

  localparam logic [3:0] IO_WRM = 4'h0;
  localparam logic [3:0] IO_WMP = 4'h1;
  localparam logic [3:0] IO_WRR = 4'h2;
  localparam logic [3:0] IO_WPM = 4'h3;
  localparam logic [3:0] IO_WR0 = 4'h4;
  localparam logic [3:0] IO_WR1 = 4'h5;
  localparam logic [3:0] IO_WR2 = 4'h6;
  localparam logic [3:0] IO_WR3 = 4'h7;
  localparam logic [3:0] IO_SBM = 4'h8;
  localparam logic [3:0] IO_RDM = 4'h9;
  localparam logic [3:0] IO_RDR = 4'hA;
  localparam logic [3:0] IO_ADM = 4'hB;
  localparam logic [3:0] IO_RD0 = 4'hC;
  localparam logic [3:0] IO_RD1 = 4'hD;
  localparam logic [3:0] IO_RD2 = 4'hE;
  localparam logic [3:0] IO_RD3 = 4'hF;

  function automatic logic is_main_rd(input logic [3:0] opa);
    return (opa == IO_SBM) || (opa == IO_RDM) || (opa == IO_ADM);
  endfunction

  // WR0-3 and RD0-3 carry the status index in opa[1:0]
  function automatic logic is_stat_wr(input logic [3:0] opa);
    return opa[3:2] == 2'b01;
  endfunction

  function automatic logic is_stat_rd(input logic [3:0] opa);
    return opa[3:2] == 2'b11;
  endfunction

endpackage

// File: rtl/bus_phase_counter.sv
// Tracks the 8-phase instruction cycle from sync; shared with the CPU-side sequencer.
module bus_phase_counter
  import ram_io_responder_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   sync_i,
  output phase_e phase_o
);

  phase_e phase_q, phase_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) phase_q <= PH_IDLE;
    else         phase_q <= phase_d;
  end

  // sync restarts the cycle from any phase; without it X3 falls back to IDLE
  always_comb begin
    phase_d = phase_q;
    if (sync_i) begin
      phase_d = PH_A1;
    end else begin
      unique case (phase_q)
        PH_IDLE: phase_d = PH_IDLE;
        PH_A1:   phase_d = PH_A2;
        PH_A2:   phase_d = PH_A3;
        PH_A3:   phase_d = PH_M1;
        PH_M1:   phase_d = PH_M2;
        PH_M2:   phase_d = PH_X1;
        PH_X1:   phase_d = PH_X2;
        PH_X2:   phase_d = PH_X3;
        PH_X3:   phase_d = PH_IDLE;
        default: phase_d = PH_IDLE;
      endcase
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/ram_io_responder.sv
// 4002-class RAM/output responder: latches SRC addresses, decodes OPR=0xE I/O
// instructions and sinks/sources RAM, status and output-port nibbles at X2.
module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter logic [1:0] CHIP_ID = 2'd0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sync,
  input  logic       cm_ram,
  input  logic [3:0] data_in,
  output logic [3:0] data_out,
  output logic       data_oe,
  output logic [3:0] port_out
);

  phase_e phase;

  logic       sel_q, src_q, opr_e_q, io_pend_q;
  logic [1:0] reg_q;
  logic [3:0] char_q, opa_q, port_q;
  logic [3:0][15:0][3:0] main_q;
  logic [3:0][3:0][3:0]  stat_q;

  logic exec, rd_main, rd_stat, wr_main, wr_stat, wr_port;

  bus_phase_counter u_phase (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .sync_i  (sync),
    .phase_o (phase)
  );

  // cm_ram at X2 means a new SRC, so it pre-empts any pending I/O
  assign exec    = (phase == PH_X2) && io_pend_q && sel_q && !cm_ram;
  assign rd_main = exec && is_main_rd(opa_q);
  assign rd_stat = exec && is_stat_rd(opa_q);
  assign wr_main = exec && (opa_q == IO_WRM);
  assign wr_port = exec && (opa_q == IO_WMP);
  assign wr_stat = exec && is_stat_wr(opa_q);

  always_comb begin
    data_out = 4'h0;
    if (rd_main)      data_out = main_q[reg_q][char_q];
    else if (rd_stat) data_out = stat_q[reg_q][opa_q[1:0]];
  end

  assign data_oe  = rd_main || rd_stat;
  assign port_out = port_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel_q     <= 1'b0;
      src_q     <= 1'b0;
      opr_e_q   <= 1'b0;
      io_pend_q <= 1'b0;
      reg_q     <= 2'd0;
      char_q    <= 4'h0;
      opa_q     <= 4'h0;
    end else begin
      unique case (phase)
        PH_M1: opr_e_q <= (data_in == OPR_IO);
        PH_M2: begin
          if (opr_e_q && cm_ram) begin
            opa_q     <= data_in;
            io_pend_q <= 1'b1;
          end
        end
        PH_X2: begin
          src_q <= cm_ram;
          if (cm_ram) begin
            sel_q     <= (data_in[3:2] == CHIP_ID);
            io_pend_q <= 1'b0;
            if (data_in[3:2] == CHIP_ID) reg_q <= data_in[1:0];
          end
        end
        PH_X3: begin
          io_pend_q <= 1'b0;
          src_q     <= 1'b0;
          if (src_q && sel_q) char_q <= data_in;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      main_q <= '0;
      stat_q <= '0;
      port_q <= 4'h0;
    end else begin
      if (wr_main) main_q[reg_q][char_q]      <= data_in;
      if (wr_stat) stat_q[reg_q][opa_q[1:0]] <= data_in;
      if (wr_port) port_q                     <= data_in;
    end
  end

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed bench for ram_io_responder (CHIP_ID=1): SRC/I-O bus cycles, reads,
// writes, output port, mid-cycle sync and mid-cycle reset.
module tb_ram_io_responder;
  import ram_io_responder_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n, sync, cm_ram;
  logic [3:0] data_in, data_out, port_out;
  logic       data_oe;

  int checks = 0;
  int failures = 0;

  logic [3:0] r_out, r_port;
  logic       r_oe, r_oth;

  ram_io_responder #(.CHIP_ID(2'd1)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .sync     (sync),
    .cm_ram   (cm_ram),
    .data_in  (data_in),
    .data_out (data_out),
    .data_oe  (data_oe),
    .port_out (port_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // inputs change just after a rising edge; outputs are observed at the falling edge
  task automatic drive(input logic s, input logic c, input logic [3:0] d);
    @(posedge clock);
    #1;
    sync = s; cm_ram = c; data_in = d;
    @(negedge clock);
  endtask

  task automatic bus_cycle(input logic [3:0] m1, input logic [3:0] m2, input logic cm2,
                           input logic [3:0] x2, input logic cmx2, input logic [3:0] x3);
    r_oth = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 4'h0); r_oth |= data_oe;
    end
    drive(1'b0, 1'b0, m1);   r_oth |= data_oe;
    drive(1'b0, cm2, m2);    r_oth |= data_oe;
    drive(1'b0, 1'b0, 4'h0); r_oth |= data_oe;
    drive(1'b0, cmx2, x2);
    r_out = data_out; r_oe = data_oe;
    drive(1'b1, 1'b0, x3);   r_oth |= data_oe;
    r_port = port_out;
  endtask

  task automatic src(input logic [3:0] addr, input logic [3:0] chr);
    bus_cycle(4'h2, 4'h1, 1'b0, addr, 1'b1, chr);
  endtask

  task automatic io(input logic [3:0] opa, input logic [3:0] d);
    bus_cycle(OPR_IO, opa, 1'b1, d, 1'b0, 4'h0);
  endtask

  initial begin
    reset_n = 1'b0; sync = 1'b0; cm_ram = 1'b0; data_in = 4'h0;
    #3;
    chk("rst_oe", {7'd0, data_oe}, 8'h00);
    chk("rst_out", {4'd0, data_out}, 8'h00);
    chk("rst_port", {4'd0, port_out}, 8'h00);
    chk("rst_phase", {4'd0, dut.u_phase.phase_o}, {4'd0, PH_IDLE});
    #9 reset_n = 1'b1;
    drive(1'b1, 1'b0, 4'h0);

    src(4'b0110, 4'h5);
    io(IO_WRM, 4'hA);
    chk("wrm_no_drive", {6'd0, r_oe, r_oth}, 8'h00);
    io(IO_RDM, 4'h0);
    chk("rdm_val", {4'd0, r_out}, 8'h0A);
    chk("rdm_oe_x2", {7'd0, r_oe}, 8'h01);
    chk("rdm_oe_other", {7'd0, r_oth}, 8'h00);

    src(4'b1010, 4'h5);
    io(IO_RDM, 4'h0);
    chk("unsel_rdm_oe", {6'd0, r_oe, r_oth}, 8'h00);
    io(IO_WRM, 4'h3);
    src(4'b0110, 4'h5);
    io(IO_RDM, 4'h0);
    chk("unsel_wrm_kept", {3'd0, r_oe, r_out}, 8'h1A);

    io(IO_WR2, 4'h7);
    chk("wr2_no_drive", {7'd0, r_oe}, 8'h00);
    io(IO_RD2, 4'h0);
    chk("rd2_val", {3'd0, r_oe, r_out}, 8'h17);
    io(IO_RD1, 4'h0);
    chk("rd1_val", {3'd0, r_oe, r_out}, 8'h10);

    io(IO_WMP, 4'h9);
    chk("wmp_port", {4'd0, r_port}, 8'h09);
    io(IO_WRR, 4'h5);
    chk("wrr_port_oe", {3'd0, r_oe, r_port}, 8'h09);
    io(IO_RDR, 4'h0);
    chk("rdr_oe", {6'd0, r_oe, r_oth}, 8'h00);

    // RDM decoded but cm_ram at X2 turns the cycle into an SRC
    bus_cycle(OPR_IO, IO_RDM, 1'b1, 4'b0110, 1'b1, 4'h5);
    chk("contention_oe", {7'd0, r_oe}, 8'h00);

    // sync at M1 restarts; cm_ram where M2 would have been lands in A1
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 4'h0);
    drive(1'b1, 1'b0, OPR_IO);
    drive(1'b0, 1'b1, IO_WRM);
    chk("midsync_phase", {4'd0, dut.u_phase.phase_o}, {4'd0, PH_A1});
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 4'h0);
    drive(1'b0, 1'b0, 4'hF);
    chk("midsync_x2_oe", {7'd0, data_oe}, 8'h00);
    drive(1'b1, 1'b0, 4'h0);
    io(IO_RDM, 4'h0);
    chk("midsync_no_write", {3'd0, r_oe, r_out}, 8'h1A);
    chk("port_held", {4'd0, port_out}, 8'h09);

    // reset pulsed in X1 with a WRM pending
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 4'h0);
    drive(1'b0, 1'b0, OPR_IO);
    drive(1'b0, 1'b1, IO_WRM);
    drive(1'b0, 1'b0, 4'h0);
    reset_n = 1'b0;
    #1;
    chk("midrst_phase", {4'd0, dut.u_phase.phase_o}, {4'd0, PH_IDLE});
    chk("midrst_port", {3'd0, data_oe, port_out}, 8'h00);
    #1 reset_n = 1'b1;
    drive(1'b0, 1'b0, 4'h5);
    chk("midrst_x2_oe", {7'd0, data_oe}, 8'h00);
    drive(1'b1, 1'b0, 4'h0);
    src(4'b0110, 4'h5);
    io(IO_RDM, 4'h0);
    chk("post_rst_main", {3'd0, r_oe, r_out}, 8'h10);
    io(IO_RD2, 4'h0);
    chk("post_rst_stat", {3'd0, r_oe, r_out}, 8'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
